// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared state type, ballot weights and voter-group widths for the vote session controller
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    TALLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W_NP   = 1;
  localparam int W_VIP  = 4;
  localparam int W_VVIP = 16;

  localparam int NP_N  = 32;
  localparam int VIP_N = 8;

endpackage

// File: rtl/vote_popcount.sv
// rtl/vote_popcount.sv - combinational population count of an N-bit vector
module vote_popcount #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  // Sum the set bits; a plain adder chain is enough at these widths.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - weighted one-vote-per-voter session controller; VVIP ballot counted only when VOTE_VVIP_EN is defined
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int THRESH = 41
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        close,
  input  logic [31:0] np,
  input  logic [7:0]  vip,
  input  logic        vvip,
  output logic [7:0]  result,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);
  localparam logic [7:0] THRESH_B = 8'(THRESH);

  state_t             state;
  state_t             state_next;
  logic [7:0]         win_cnt;
  logic [NP_N-1:0]    np_mask;
  logic [VIP_N-1:0]   vip_mask;
  logic [NP_N-1:0]    np_new;
  logic [VIP_N-1:0]   vip_new;
  logic [5:0]         np_cnt;
  logic [3:0]         vip_cnt;
  logic [7:0]         add_val;

  assign np_new  = np  & ~np_mask;
  assign vip_new = vip & ~vip_mask;

  vote_popcount #(.N(NP_N)) u_np_count (
    .bits  (np_new),
    .count (np_cnt)
  );

  vote_popcount #(.N(VIP_N)) u_vip_count (
    .bits  (vip_new),
    .count (vip_cnt)
  );

`ifdef VOTE_VVIP_EN
  logic vvip_mask;
  logic vvip_new;

  assign vvip_new = vvip & ~vvip_mask;

  // Weighted sum of this cycle's first-time ballots, VVIP included.
  always_comb begin
    add_val = 8'(int'(np_cnt) * W_NP + int'(vip_cnt) * W_VIP + int'(vvip_new) * W_VVIP);
  end

  // The single VVIP voted bit: cleared on session open, set once the VVIP has voted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vvip_mask <= 1'b0;
    end else if (state == IDLE && start) begin
      vvip_mask <= 1'b0;
    end else if (state == OPEN) begin
      vvip_mask <= vvip_mask | vvip;
    end
  end
`else
  logic unused_vvip;
  assign unused_vvip = vvip;

  // Weighted sum of this cycle's first-time ballots; the VVIP seat does not exist here.
  always_comb begin
    add_val = 8'(int'(np_cnt) * W_NP + int'(vip_cnt) * W_VIP);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status decode; busy/done follow the state so reset clears them at once.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = OPEN;
      end
      OPEN: begin
        busy = 1'b1;
        if (close || win_cnt == WIN_LAST) state_next = TALLY;
      end
      TALLY: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Session datapath: clear on open, accumulate first-time ballots in OPEN, decide pass in TALLY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result   <= 8'd0;
      pass     <= 1'b0;
      win_cnt  <= 8'd0;
      np_mask  <= '0;
      vip_mask <= '0;
    end else if (state == IDLE && start) begin
      result   <= 8'd0;
      pass     <= 1'b0;
      win_cnt  <= 8'd0;
      np_mask  <= '0;
      vip_mask <= '0;
    end else if (state == OPEN) begin
      result   <= result + add_val;
      win_cnt  <= win_cnt + 8'd1;
      np_mask  <= np_mask | np;
      vip_mask <= vip_mask | vip;
    end else if (state == TALLY) begin
      pass <= (result >= THRESH_B);
    end
  end

endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter WINDOW, default 16: maximum OPEN-state cycles before automatic close; legal range 2..255.
REQ-002 Parameter THRESH, default 41: pass threshold compared against the final tally.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: opens a session; sampled in IDLE only.
REQ-006 Port close, input, 1: ends the session early; sampled in OPEN only.
REQ-007 Port np, input, 32: normal-voter ballots, 1 = yes; each bit has weight 1.
REQ-008 Port vip, input, 8: VIP ballots, 1 = yes; each bit has weight 4.
REQ-009 Port vvip, input, 1: VVIP ballot, 1 = yes; weight 16.
REQ-010 Port result, output, 8: registered running weighted tally.
REQ-011 Port busy, output, 1: high in OPEN and TALLY.
REQ-012 Port done, output, 1: one-cycle pulse in DONE.
REQ-013 Port pass, output, 1: registered; high when result >= THRESH; valid from DONE until the next start.

Function
REQ-014 The FSM SHALL have states IDLE, OPEN, TALLY and DONE.
- IDLE->OPEN on start.
- OPEN->TALLY on close, or when the window counter equals WINDOW-1.
- TALLY->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-015 Entering OPEN SHALL clear result, pass, the window counter and the per-voter voted masks (32+8+1 bits).
REQ-016 In OPEN, each cycle's new votes SHALL equal the inputs ANDed with the inverted voted mask.
- New votes set their mask bits.
- result += popcount(np_new) + 4*popcount(vip_new) + 16*vvip_new.
- The added value is visible in result the following cycle.
REQ-017 Each voter SHALL be counted at most once per session; holding or re-pulsing a ballot has no further effect.
REQ-018 Maximum tally is 80, so result SHALL NOT overflow 8 bits; no saturation logic.
REQ-019 Votes present in the same cycle as close or timeout SHALL be counted.
REQ-020 Ballot inputs SHALL be ignored in IDLE, TALLY and DONE.
REQ-021 In TALLY, pass SHALL be registered as (result >= THRESH).
REQ-022 start outside IDLE and close outside OPEN SHALL be ignored; start in the DONE cycle is lost.
REQ-023 result and pass SHALL hold their values in DONE and IDLE until the next session opens.

Reset
REQ-024 While reset is low, the block SHALL immediately force:
- state to IDLE;
- result, busy, done and pass to 0;
- the counter and masks to 0.
REQ-025 Reset asserted mid-session SHALL discard the session; no done pulse is produced.

Configuration
REQ-026 With VOTE_VVIP_EN defined, vvip SHALL be counted with weight 16.
REQ-027 Without VOTE_VVIP_EN, vvip SHALL be ignored, its mask bit SHALL not exist, and the maximum tally SHALL be 64.

Structure
REQ-028 Package vote_pkg SHALL hold:
- the state enum typedef;
- weight constants W_NP=1, W_VIP=4, W_VVIP=16;
- width constants NP_N=32, VIP_N=8.
REQ-029 A sub-module vote_popcount SHALL be used: parameterised width N, combinational population count, instantiated once for np and once for vip.

Verification
REQ-030 The bench SHALL cover these scenarios:
- Tally and fail: start; one OPEN cycle with np=32'h8888_8888, vip=8'h88, vvip=1; then close. Required: result=8'd32, pass=0, done high for exactly 1 cycle, busy low after DONE.
- Sticky votes: the same ballots held for 3 OPEN cycles, then close. Required: result=8'd32.
- Full vote and pass: np=32'hFFFF_FFFF, vip=8'hFF, vvip=1 in the same cycle as close. Required: result=8'd80, pass=1.
- Timeout: start, no close, np=32'h1 on the first OPEN cycle. Required: TALLY entered after the 16th OPEN cycle, result=1, pass=0, done pulses.
- Reset and ignored start: reset low mid-OPEN. Required: result, busy, done and pass all 0 immediately, state IDLE. start asserted during DONE produces no new session.
- Macro off (build without VOTE_VVIP_EN): vvip=1 alone, then close. Required: result=0.
